// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared defaults, index-width helper and game state for the tile row buffer
package tile_pkg;

    localparam int LANES_DEF = 4;
    localparam int ROWS_DEF  = 8;

    typedef enum logic {
        RUN  = 1'b0,
        OVER = 1'b1
    } state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tile_row_buffer_if.sv
// rtl/tile_row_buffer_if.sv - control, write, judge and display-read bundle of the tile row buffer
interface tile_row_buffer_if
    import tile_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int ROWS  = ROWS_DEF
);
    localparam int LW = idx_w(LANES);
    localparam int RW = idx_w(ROWS);

    logic          clear;
    logic          wr_valid;
    logic [LW-1:0] wr_lane;
    logic          wr_ready;
    logic          scroll;
    logic          hit_valid;
    logic [LW-1:0] hit_lane;
    logic [RW-1:0] rd_row;
    logic [LW-1:0] rd_lane;
    logic          rd_occ;
    logic [RW:0]   count;
    logic          hit_ok;
    logic          miss;
    logic          bad_wr;
    logic          game_over;

    modport master (
        output clear, wr_valid, wr_lane, scroll, hit_valid, hit_lane, rd_row,
        input  wr_ready, rd_lane, rd_occ, count, hit_ok, miss, bad_wr, game_over
    );

    modport slave (
        input  clear, wr_valid, wr_lane, scroll, hit_valid, hit_lane, rd_row,
        output wr_ready, rd_lane, rd_occ, count, hit_ok, miss, bad_wr, game_over
    );

endinterface

// File: rtl/tile_ring.sv
// rtl/tile_ring.sv - circular row store with head/count, push/pop and offset read
module tile_ring #(
    parameter int ROWS = 8,
    parameter int LW   = 2,
    parameter int RW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [LW-1:0] push_lane,
    input  logic          pop,
    input  logic [RW-1:0] rd_row,
    output logic [LW-1:0] rd_lane,
    output logic [LW-1:0] head_lane,
    output logic          rd_occ,
    output logic          full,
    output logic [RW:0]   count
);
    logic [LW-1:0] mem [ROWS];
    logic [RW-1:0] head;
    logic [RW-1:0] tail;
    logic [RW-1:0] rd_idx;

    // ROWS is a power of two, so RW-bit addition wraps modulo ROWS for free.
    assign tail      = head + count[RW-1:0];
    assign rd_idx    = head + rd_row;
    assign rd_lane   = mem[rd_idx];
    assign head_lane = mem[head];
    assign rd_occ    = {1'b0, rd_row} < count;
    assign full      = count == (RW+1)'(ROWS);

    // Row storage; when full and popping, tail aliases head and the popped slot is reused.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[tail] <= push_lane;
        end
    end

    // Head pointer and occupancy; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + (RW+1)'(push) - (RW+1)'(pop);
        end
    end

endmodule

// File: rtl/tile_row_buffer.sv
// rtl/tile_row_buffer.sv - scrolling tile row queue with press judging and game-over state
module tile_row_buffer
    import tile_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int ROWS  = ROWS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    tile_row_buffer_if.slave       bus
);
    localparam int LW = idx_w(LANES);
    localparam int RW = idx_w(ROWS);

    state_t        state, state_n;
    logic          push, pop;
    logic          full;
    logic [LW-1:0] head_lane;
    logic          lane_ok;
    logic          hit_ok_n, miss_n, bad_set;

    assign lane_ok       = int'(bus.wr_lane) < LANES;
    assign bus.game_over = (state == OVER);

    tile_ring #(
        .ROWS (ROWS),
        .LW   (LW),
        .RW   (RW)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.clear),
        .push      (push),
        .push_lane (bus.wr_lane),
        .pop       (pop),
        .rd_row    (bus.rd_row),
        .rd_lane   (bus.rd_lane),
        .head_lane (head_lane),
        .rd_occ    (bus.rd_occ),
        .full      (full),
        .count     (bus.count)
    );

    // Judge the bottom row (press before scroll), decide pop/push and the next state.
    always_comb begin
        state_n      = state;
        push         = 1'b0;
        pop          = 1'b0;
        hit_ok_n     = 1'b0;
        miss_n       = 1'b0;
        bad_set      = 1'b0;
        bus.wr_ready = 1'b0;
        if (bus.clear) begin
            state_n = RUN;
        end else if (state == RUN) begin
            if (bus.hit_valid && bus.count != '0) begin
                if (bus.hit_lane == head_lane) begin
                    pop      = 1'b1;
                    hit_ok_n = 1'b1;
                end else begin
                    miss_n  = 1'b1;
                    state_n = OVER;
                end
            end else if (bus.scroll && bus.count != '0) begin
                pop     = 1'b1;
                miss_n  = 1'b1;
                state_n = OVER;
            end
            bus.wr_ready = !full || pop;
            if (bus.wr_valid && bus.wr_ready) begin
                if (lane_ok) begin
                    push = 1'b1;
                end else begin
                    bad_set = 1'b1;
                end
            end
        end
    end

    // State register plus the registered pulses and sticky bad-write flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            bus.hit_ok <= 1'b0;
            bus.miss   <= 1'b0;
            bus.bad_wr <= 1'b0;
        end else begin
            state      <= state_n;
            bus.hit_ok <= hit_ok_n;
            bus.miss   <= miss_n;
            if (bus.clear) begin
                bus.bad_wr <= 1'b0;
            end else if (bad_set) begin
                bus.bad_wr <= 1'b1;
            end
        end
    end

endmodule
